row_accum_tree: RTL and testbench

// Parametrised row-sum engine for the sparse matrix-vector datapath. It takes a

---
 rtl/row_accum_tree.sv | 224 ++++++++++++++++++++++
 tb/tb_row_accum_tree.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_accum_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : row_accum_tree
// Description : Row-sum engine for the sparse matrix-vector datapath. Signed
//               products of one row are spread round-robin over LANES
//               interleaved accumulators. At end of row the partial sums are
//               snapshotted and reduced by a registered log2(LANES)-level
//               adder tree to a valid/ready output port.
//
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset, clears all state
//               i_in_valid   input element valid
//               o_in_ready   engine can accept (combinational from i_out_ready)
//               i_in_data    signed product, DATA_W bits
//               i_in_last    final element of current row
//               i_in_empty   with i_in_last: beat carries no element
//               o_out_valid  row result valid
//               i_out_ready  consumer accepts result
//               o_out_sum    signed row sum, DATA_W+GUARD bits
//               o_out_count  number of elements summed (saturating)
//               o_out_ovf    an add in this row saturated / overflowed
//
// Revision    : 1.0  initial release
// ============================================================================
module row_accum_tree #(
    parameter int DATA_W = 24,
    parameter int LANES  = 4,   // power of two, >= 2
    parameter int GUARD  = 8,
    parameter int CNT_W  = 11,
    parameter int SAT    = 0    // 0: wrap, 1: saturate at every add
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [DATA_W-1:0]         i_in_data,
    input  logic                      i_in_last,
    input  logic                      i_in_empty,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [DATA_W+GUARD-1:0]   o_out_sum,
    output logic [CNT_W-1:0]          o_out_count,
    output logic                      o_out_ovf
);

    localparam int c_sum_w = DATA_W + GUARD;
    localparam int c_lvls  = $clog2(LANES);
    localparam int c_nodes = 2 * LANES - 1;

    localparam logic [c_sum_w-1:0] c_sum_max = {1'b0, {(c_sum_w-1){1'b1}}};
    localparam logic [c_sum_w-1:0] c_sum_min = {1'b1, {(c_sum_w-1){1'b0}}};
    localparam logic [CNT_W-1:0]   c_cnt_max = '1;

    // Signed add returning {overflow, result}. On overflow the result is
    // either wrapped or clamped toward the sign of the operands.
    function automatic logic [c_sum_w:0] f_add(input logic [c_sum_w-1:0] a,
                                               input logic [c_sum_w-1:0] b);
        logic [c_sum_w-1:0] s;
        logic               ov;
        s  = a + b;
        ov = (a[c_sum_w-1] == b[c_sum_w-1]) && (s[c_sum_w-1] != a[c_sum_w-1]);
        if ((SAT != 0) && ov) begin
            s = a[c_sum_w-1] ? c_sum_min : c_sum_max;
        end
        return {ov, s};
    endfunction

    // ------------------------------------------------------------------
    // Accumulator state
    // ------------------------------------------------------------------
    logic [c_sum_w-1:0] r_acc [LANES];
    logic [c_lvls-1:0]  r_ptr;
    logic [CNT_W-1:0]   r_cnt_acc;
    logic               r_acc_ovf;

    // ------------------------------------------------------------------
    // Tree state. Nodes use heap numbering: root is node 0, children of
    // node n are 2n+1 and 2n+2, leaves (the S0 snapshot) are LANES-1 ..
    // 2*LANES-2. Level k (0 = snapshot, c_lvls = output) carries one
    // valid, count and ovf flag.
    // ------------------------------------------------------------------
    logic [c_sum_w-1:0] r_node    [c_nodes];
    logic [c_lvls:0]    r_vld;
    logic [CNT_W-1:0]   r_lvl_cnt [c_lvls+1];
    logic [c_lvls:0]    r_lvl_ovf;

    logic               w_adv;
    logic               w_accept;
    logic               w_row_done;
    logic [c_sum_w-1:0] w_ext;
    logic [c_sum_w-1:0] w_lane_sum;
    logic               w_lane_ovf;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_s0_cnt;
    logic               w_s0_ovf;
    logic [c_sum_w-1:0] w_leaf     [LANES];
    logic [c_sum_w-1:0] w_node_sum [LANES-1];
    logic [LANES-2:0]   w_node_ovf;
    logic [LANES-2:0]   w_node_load;
    logic [c_lvls:1]    w_lvl_add_ovf;

    // Whole engine advances together; a stalled output freezes every stage.
    assign w_adv      = !r_vld[c_lvls] || i_out_ready;
    assign o_in_ready = w_adv;
    assign w_accept   = i_in_valid && w_adv;
    assign w_row_done = w_accept && i_in_last;

    assign w_ext = c_sum_w'($signed(i_in_data));
    assign {w_lane_ovf, w_lane_sum} = f_add(r_acc[r_ptr], w_ext);

    assign w_cnt_inc = (r_cnt_acc == c_cnt_max) ? r_cnt_acc : r_cnt_acc + CNT_W'(1);
    assign w_s0_cnt  = i_in_empty ? r_cnt_acc : w_cnt_inc;
    assign w_s0_ovf  = r_acc_ovf || (!i_in_empty && w_lane_ovf);

    // Snapshot view: accumulators with the final element folded into the
    // current lane (unless the closing beat is empty).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_leaf[i] = r_acc[i];
            if (!i_in_empty && (int'(r_ptr) == i)) begin
                w_leaf[i] = w_lane_sum;
            end
        end
    end

    // Internal tree nodes: pairwise adders and their load enables.
    for (genvar n = 0; n < LANES - 1; n++) begin : g_node
        localparam int c_depth = $clog2(n + 2) - 1;
        assign {w_node_ovf[n], w_node_sum[n]} = f_add(r_node[2*n+1], r_node[2*n+2]);
        // Node at depth d belongs to level c_lvls-d, fed by level c_lvls-d-1.
        assign w_node_load[n] = w_adv && r_vld[c_lvls-1-c_depth];
    end

    // Any overflowing adder in a level flags the row passing through it.
    for (genvar k = 1; k <= c_lvls; k++) begin : g_lvl
        localparam int c_d     = c_lvls - k;
        localparam int c_first = (1 << c_d) - 1;
        localparam int c_num   = 1 << c_d;
        assign w_lvl_add_ovf[k] = |w_node_ovf[c_first +: c_num];
    end

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
            r_ptr     <= '0;
            r_cnt_acc <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_accept) begin
            if (i_in_last) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= '0;
                end
                r_ptr     <= '0;
                r_cnt_acc <= '0;
                r_acc_ovf <= 1'b0;
            end else if (!i_in_empty) begin
                r_acc[r_ptr] <= w_lane_sum;
                r_ptr        <= r_ptr + c_lvls'(1);
                r_cnt_acc    <= w_cnt_inc;
                r_acc_ovf    <= r_acc_ovf || w_lane_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot and tree data; data registers load only with valid rows so
    // the output holds its last value between results.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < c_nodes; n++) begin
                r_node[n] <= '0;
            end
        end else begin
            for (int n = 0; n < LANES - 1; n++) begin
                if (w_node_load[n]) begin
                    r_node[n] <= w_node_sum[n];
                end
            end
            if (w_row_done) begin
                for (int i = 0; i < LANES; i++) begin
                    r_node[LANES-1+i] <= w_leaf[i];
                end
            end
        end
    end

    // Per-level valid / count / ovf side-band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_lvl_ovf <= '0;
            for (int k = 0; k <= c_lvls; k++) begin
                r_lvl_cnt[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= w_row_done;
            if (w_row_done) begin
                r_lvl_cnt[0] <= w_s0_cnt;
                r_lvl_ovf[0] <= w_s0_ovf;
            end
            for (int k = 1; k <= c_lvls; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_lvl_cnt[k] <= r_lvl_cnt[k-1];
                    r_lvl_ovf[k] <= r_lvl_ovf[k-1] || w_lvl_add_ovf[k];
                end
            end
        end
    end

    assign o_out_valid = r_vld[c_lvls];
    assign o_out_sum   = r_node[0];
    assign o_out_count = r_lvl_cnt[c_lvls];
    assign o_out_ovf   = r_lvl_ovf[c_lvls];

endmodule
`default_nettype wire

// File: tb/tb_row_accum_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_row_accum_tree
// Description : Directed self-checking bench for row_accum_tree. Instance A
//               uses default parameters; instances B (SAT=1, GUARD=0,
//               CNT_W=3) and C (SAT=0, GUARD=0) share one input stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_row_accum_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A
    logic        a_in_valid, a_in_ready, a_in_last, a_in_empty;
    logic [23:0] a_in_data;
    logic        a_out_valid, a_out_ready, a_out_ovf;
    logic [31:0] a_out_sum;
    logic [10:0] a_out_count;

    // Instances B and C (shared inputs)
    logic        b_in_valid, b_in_last, b_in_empty, b_out_ready;
    logic [23:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [23:0] b_out_sum;
    logic [2:0]  b_out_count;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [23:0] c_out_sum;
    logic [10:0] c_out_count;

    row_accum_tree #(.DATA_W(24), .LANES(4), .GUARD(8), .CNT_W(11), .SAT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .i_in_last(a_in_last), .i_in_empty(a_in_empty),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_out_sum(a_out_sum), .o_out_count(a_out_count), .o_out_ovf(a_out_ovf)
    );

    row_accum_tree #(.DATA_W(24), .LANES(4), .GUARD(0), .CNT_W(3), .SAT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .i_in_last(b_in_last), .i_in_empty(b_in_empty),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
        .o_out_sum(b_out_sum), .o_out_count(b_out_count), .o_out_ovf(b_out_ovf)
    );

    row_accum_tree #(.DATA_W(24), .LANES(4), .GUARD(0), .CNT_W(11), .SAT(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(c_in_ready), .i_in_data(b_in_data),
        .i_in_last(b_in_last), .i_in_empty(b_in_empty),
        .o_out_valid(c_out_valid), .i_out_ready(b_out_ready),
        .o_out_sum(c_out_sum), .o_out_count(c_out_count), .o_out_ovf(c_out_ovf)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [23:0] d, input logic last, input logic empty);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = last;
        a_in_empty = empty;
        chk("a_in_ready", 64'(a_in_ready), 64'(1'b1));
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        a_in_empty = 1'b0;
    endtask

    task automatic send_b(input logic [23:0] d, input logic last);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = last;
        chk("bc_in_ready", 64'({b_in_ready, c_in_ready}), 64'(2'b11));
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    // Output of a row appears two edges after the accepting edge (LANES=4).
    task automatic wait_out(input string tag);
        tick();
        chk({tag, "_early"}, 64'(a_out_valid), 64'(1'b0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_in_empty = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_in_empty = 1'b0;
        b_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(a_out_valid), 64'(1'b0));
        chk("rst_sum",   64'(a_out_sum),   64'(32'd0));
        chk("rst_count", 64'(a_out_count), 64'(11'd0));
        chk("rst_ovf",   64'(a_out_ovf),   64'(1'b0));
        rst_n = 1'b1;
        tick();

        // Row 1..5
        send_a(24'd1, 1'b0, 1'b0);
        send_a(24'd2, 1'b0, 1'b0);
        send_a(24'd3, 1'b0, 1'b0);
        send_a(24'd4, 1'b0, 1'b0);
        send_a(24'd5, 1'b1, 1'b0);
        wait_out("r15");
        chk("r15_valid", 64'(a_out_valid), 64'(1'b1));
        chk("r15_sum",   64'(a_out_sum),   64'(32'd15));
        chk("r15_count", 64'(a_out_count), 64'(11'd5));
        chk("r15_ovf",   64'(a_out_ovf),   64'(1'b0));

        // Negatives: -7, +3
        send_a(24'hFFFFF9, 1'b0, 1'b0);
        send_a(24'd3, 1'b1, 1'b0);
        wait_out("neg");
        chk("neg_sum",   64'(a_out_sum),   64'(32'hFFFFFFFC));
        chk("neg_count", 64'(a_out_count), 64'(11'd2));

        // Single element
        send_a(24'd9, 1'b1, 1'b0);
        wait_out("one");
        chk("one_sum",   64'(a_out_sum),   64'(32'd9));
        chk("one_count", 64'(a_out_count), 64'(11'd1));

        // Empty row; in_data must be ignored
        send_a(24'h7FFFFF, 1'b1, 1'b1);
        wait_out("empty");
        chk("empty_valid", 64'(a_out_valid), 64'(1'b1));
        chk("empty_sum",   64'(a_out_sum),   64'(32'd0));
        chk("empty_count", 64'(a_out_count), 64'(11'd0));

        // 5, (empty without last: ignored), 6, closing empty beat -> 11, count 2
        send_a(24'd5, 1'b0, 1'b0);
        send_a(24'h55, 1'b0, 1'b1);
        send_a(24'd6, 1'b0, 1'b0);
        send_a(24'h123456, 1'b1, 1'b1);
        wait_out("tail");
        chk("tail_sum",   64'(a_out_sum),   64'(32'd11));
        chk("tail_count", 64'(a_out_count), 64'(11'd2));
        tick();
        chk("drain_valid", 64'(a_out_valid), 64'(1'b0));

        // Back-to-back rows under backpressure
        a_out_ready = 1'b0;
        send_a(24'd10, 1'b1, 1'b0);
        send_a(24'd20, 1'b1, 1'b0);
        send_a(24'd30, 1'b1, 1'b0);
        chk("bp_ready0", 64'(a_in_ready),  64'(1'b0));
        chk("bp_valid",  64'(a_out_valid), 64'(1'b1));
        chk("bp_sum10",  64'(a_out_sum),   64'(32'd10));
        repeat (5) tick();
        chk("bp_hold_sum",   64'(a_out_sum),  64'(32'd10));
        chk("bp_hold_ready", 64'(a_in_ready), 64'(1'b0));
        a_out_ready = 1'b1;
        #1;
        chk("bp_ready1", 64'(a_in_ready), 64'(1'b1));
        tick();
        chk("bp_v20",    64'(a_out_valid), 64'(1'b1));
        chk("bp_sum20",  64'(a_out_sum),   64'(32'd20));
        tick();
        chk("bp_v30",    64'(a_out_valid), 64'(1'b1));
        chk("bp_sum30",  64'(a_out_sum),   64'(32'd30));
        chk("bp_cnt30",  64'(a_out_count), 64'(11'd1));
        tick();
        chk("bp_empty",  64'(a_out_valid), 64'(1'b0));

        // Reset mid-row; output register still holds 30 before reset
        send_a(24'd100, 1'b0, 1'b0);
        send_a(24'd100, 1'b0, 1'b0);
        send_a(24'd100, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst_valid", 64'(a_out_valid), 64'(1'b0));
        chk("mrst_sum",   64'(a_out_sum),   64'(32'd0));
        chk("mrst_count", 64'(a_out_count), 64'(11'd0));
        chk("mrst_ovf",   64'(a_out_ovf),   64'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        send_a(24'd4, 1'b0, 1'b0);
        send_a(24'd4, 1'b1, 1'b0);
        wait_out("post");
        chk("post_sum",   64'(a_out_sum),   64'(32'd8));
        chk("post_count", 64'(a_out_count), 64'(11'd2));

        // Positive overflow: B saturates, C wraps
        send_b(24'h7FFFFF, 1'b0);
        send_b(24'h7FFFFF, 1'b1);
        tick();
        tick();
        chk("pos_valid",  64'({b_out_valid, c_out_valid}), 64'(2'b11));
        chk("pos_b_sum",  64'(b_out_sum), 64'(24'h7FFFFF));
        chk("pos_b_ovf",  64'(b_out_ovf), 64'(1'b1));
        chk("pos_c_sum",  64'(c_out_sum), 64'(24'hFFFFFE));
        chk("pos_c_ovf",  64'(c_out_ovf), 64'(1'b1));
        chk("pos_b_cnt",  64'(b_out_count), 64'(3'd2));

        // Negative overflow: B clamps to min, C wraps to 0
        send_b(24'h800000, 1'b0);
        send_b(24'h800000, 1'b1);
        tick();
        tick();
        chk("neg_b_sum", 64'(b_out_sum), 64'(24'h800000));
        chk("neg_b_ovf", 64'(b_out_ovf), 64'(1'b1));
        chk("neg_c_sum", 64'(c_out_sum), 64'(24'h000000));
        chk("neg_c_ovf", 64'(c_out_ovf), 64'(1'b1));

        // Nine ones: B count saturates at 7, C counts 9; ovf cleared per row
        for (int i = 0; i < 8; i++) begin
            send_b(24'd1, 1'b0);
        end
        send_b(24'd1, 1'b1);
        tick();
        tick();
        chk("cnt_b_sum",   64'(b_out_sum),   64'(24'd9));
        chk("cnt_b_count", 64'(b_out_count), 64'(3'd7));
        chk("cnt_b_ovf",   64'(b_out_ovf),   64'(1'b0));
        chk("cnt_c_count", 64'(c_out_count), 64'(11'd9));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
